piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 147 ++++++++++++++
 tb/tb_piso_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Purpose : parallel-in/serial-out shifter; a WIDTH-bit word taken on a ready/valid
//           load is sent one bit per DIV clocks, MSB- or LSB-first.
// Latency : first bit on sout the cycle after the accepting edge; done pulses
//           WIDTH*DIV+1 cycles after the accepting edge.
// Backpressure: load_ready is high only when idle or during the final clock of
//           the final bit, so words stream back-to-back with no idle gap.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   din, load_valid   parallel word and its valid (sampled only on accept)
//   load_ready        block will take din on this edge if load_valid is high
//   sout, sout_valid  registered serial bit and its qualifier
//   busy              registered, high while a word is shifting
//   done              one-cycle pulse after the last bit period of each word
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int DIV        = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("piso_serializer: WIDTH must be >= 2");
    end
    if (DIV < 1) begin : g_bad_div
      $error("piso_serializer: DIV must be >= 1");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;

  logic             tick;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] shreg_nxt;
  logic             next_bit;
  logic             first_bit;

  // With DIV == 1 the divider counter stays at zero, so tick is constantly high.
  assign tick   = (div_cnt == DIV_LAST);
  assign last   = (state == SHIFT) && (bit_cnt == BIT_LAST) && tick;

  // Ready during the last clock of the last bit lets the next word follow
  // immediately. Gated by rst so it drops asynchronously with reset.
  assign load_ready = ~rst && ((state == IDLE) || last);
  assign accept     = load_valid && load_ready;

  // The bit currently on sout is always the outgoing end of shreg; next_bit is
  // the one that becomes outgoing after a shift.
  always_comb begin
    shreg_nxt = '0;
    next_bit  = 1'b0;
    first_bit = 1'b0;
    if (MSB_FIRST) begin
      shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
      next_bit  = shreg[WIDTH-2];
      first_bit = din[WIDTH-1];
    end else begin
      shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
      next_bit  = shreg[1];
      first_bit = din[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // done follows the final bit period whether or not a new word reloads.
      done <= last;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SHIFT;
            shreg      <= din;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            sout       <= first_bit;
            sout_valid <= 1'b1;
            busy       <= 1'b1;
          end else begin
            sout       <= IDLE_LEVEL;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        SHIFT: begin
          if (accept) begin
            // Only reachable when last is high: seamless reload.
            shreg      <= din;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            sout       <= first_bit;
            sout_valid <= 1'b1;
            busy       <= 1'b1;
          end else if (last) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            sout       <= IDLE_LEVEL;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (tick) begin
            div_cnt    <= '0;
            bit_cnt    <= bit_cnt + 1'b1;
            shreg      <= shreg_nxt;
            sout       <= next_bit;
          end else begin
            div_cnt    <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances share clk/rst
// (u0: DIV=1 MSB-first, u1: DIV=1 LSB-first, u2: DIV=3 MSB-first).
// Inputs change and outputs are sampled on the falling edge.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [2:0] lv;
  logic [7:0] din_u [3];
  logic [2:0] rdy;
  logic [2:0] so;
  logic [2:0] sv;
  logic [2:0] bz;
  logic [2:0] dn;

  int nvec = 0;
  int nerr = 0;

  piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .rst(rst), .din(din_u[0]), .load_valid(lv[0]), .load_ready(rdy[0]),
    .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0])
  );

  piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
    .clk(clk), .rst(rst), .din(din_u[1]), .load_valid(lv[1]), .load_ready(rdy[1]),
    .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1])
  );

  piso_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u2 (
    .clk(clk), .rst(rst), .din(din_u[2]), .load_valid(lv[2]), .load_ready(rdy[2]),
    .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]), .done(dn[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present w on instance u for one accepting edge; returns in cycle T+1.
  task automatic load(input int u, input logic [7:0] w, input string tag);
    chk({tag, " ready_before_load"}, 32'(rdy[u]), 32'd1);
    din_u[u] = w;
    lv[u]    = 1'b1;
    @(negedge clk);
    lv[u]    = 1'b0;
  endtask

  // Check all WIDTH*div cycles of a word, starting in cycle T+1.
  task automatic expect_word(input int u, input logic [7:0] w, input int div,
                             input bit msb, input string tag);
    logic b;
    for (int k = 0; k < 8; k++) begin
      b = msb ? w[7-k] : w[k];
      for (int d = 0; d < div; d++) begin
        chk($sformatf("%s sout bit%0d.%0d", tag, k, d), 32'(so[u]), 32'(b));
        chk($sformatf("%s sout_valid bit%0d.%0d", tag, k, d), 32'(sv[u]), 32'd1);
        chk($sformatf("%s busy bit%0d.%0d", tag, k, d), 32'(bz[u]), 32'd1);
        chk($sformatf("%s done bit%0d.%0d", tag, k, d), 32'(dn[u]), 32'd0);
        @(negedge clk);
      end
    end
  endtask

  // Cycle after the last bit period: idle outputs plus a one-cycle done.
  task automatic expect_end(input int u, input string tag);
    chk({tag, " done_pulse"}, 32'(dn[u]), 32'd1);
    chk({tag, " sout_idle"}, 32'(so[u]), 32'd0);
    chk({tag, " sout_valid_low"}, 32'(sv[u]), 32'd0);
    chk({tag, " busy_low"}, 32'(bz[u]), 32'd0);
    chk({tag, " ready_idle"}, 32'(rdy[u]), 32'd1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(dn[u]), 32'd0);
  endtask

  initial begin
    logic [15:0] seq;
    rst = 1'b1;
    lv  = '0;
    for (int i = 0; i < 3; i++) din_u[i] = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset u%0d load_ready", i), 32'(rdy[i]), 32'd0);
      chk($sformatf("reset u%0d sout", i), 32'(so[i]), 32'd0);
      chk($sformatf("reset u%0d sout_valid", i), 32'(sv[i]), 32'd0);
      chk($sformatf("reset u%0d busy", i), 32'(bz[i]), 32'd0);
      chk($sformatf("reset u%0d done", i), 32'(dn[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset load_ready", 32'(rdy[0]), 32'd1);

    // 1: MSB-first A5
    load(0, 8'hA5, "t1");
    expect_word(0, 8'hA5, 1, 1'b1, "t1");
    expect_end(0, "t1");

    // 2: LSB-first A5 and 01
    load(1, 8'hA5, "t2a");
    expect_word(1, 8'hA5, 1, 1'b0, "t2a");
    expect_end(1, "t2a");
    load(1, 8'h01, "t2b");
    expect_word(1, 8'h01, 1, 1'b0, "t2b");
    expect_end(1, "t2b");

    // 3: DIV=3, F0
    load(2, 8'hF0, "t3");
    expect_word(2, 8'hF0, 3, 1'b1, "t3");
    expect_end(2, "t3");

    // 4: back-to-back A5 then 3C with load_valid held
    seq      = 16'hA53C;
    din_u[0] = 8'hA5;
    lv[0]    = 1'b1;
    @(negedge clk);
    din_u[0] = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t4 sout bit%0d", k), 32'(so[0]), 32'(seq[15-k]));
      chk($sformatf("t4 sout_valid bit%0d", k), 32'(sv[0]), 32'd1);
      chk($sformatf("t4 load_ready bit%0d", k), 32'(rdy[0]),
          32'((k == 7) || (k == 15)));
      chk($sformatf("t4 done bit%0d", k), 32'(dn[0]), 32'(k == 8));
      if (k == 8) lv[0] = 1'b0;
      @(negedge clk);
    end
    expect_end(0, "t4");

    // 5: load attempt mid-word is ignored
    load(0, 8'h00, "t5");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t5 sout bit%0d", k), 32'(so[0]), 32'd0);
      chk($sformatf("t5 sout_valid bit%0d", k), 32'(sv[0]), 32'd1);
      if (k == 3) begin
        din_u[0] = 8'hFF;
        lv[0]    = 1'b1;
        chk("t5 load_ready mid_word", 32'(rdy[0]), 32'd0);
      end else begin
        lv[0] = 1'b0;
      end
      @(negedge clk);
    end
    expect_end(0, "t5");

    // 6: asynchronous reset mid-word, then a clean word
    load(0, 8'hA5, "t6");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6 sout bit%0d", k), 32'(so[0]), 32'(seq[15-k]));
      @(negedge clk);
    end
    chk("t6 sout bit4", 32'(so[0]), 32'd0);
    chk("t6 busy bit4", 32'(bz[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6 async sout", 32'(so[0]), 32'd0);
    chk("t6 async sout_valid", 32'(sv[0]), 32'd0);
    chk("t6 async busy", 32'(bz[0]), 32'd0);
    chk("t6 async done", 32'(dn[0]), 32'd0);
    chk("t6 async load_ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6 no_done_after_abort", 32'(dn[0]), 32'd0);
    chk("t6 idle_after_abort", 32'(bz[0]), 32'd0);
    load(0, 8'h81, "t6b");
    expect_word(0, 8'h81, 1, 1'b1, "t6b");
    expect_end(0, "t6b");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
